// File: rtl/reg_dump_reader_if.sv
// Debug dump bus: request/status, register-file debug read port and byte stream.
interface reg_dump_reader_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              start;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_data;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              busy;
    logic              done;

    modport master (
        input  start, dbg_data, out_ready,
        output dbg_addr, out_valid, out_data, busy, done
    );

    modport slave (
        output start, dbg_data, out_ready,
        input  dbg_addr, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/reg_dump_reader.sv
// Register file debug readout: walks x0..x(N_REGS-1) on the debug read port
// and serializes each 32-bit value MSB byte first over a valid/ready stream.
// Optional: define REG_DUMP_INDEX_EN to prefix every register with an index byte.
module reg_dump_reader #(
    parameter int unsigned N_REGS = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    reg_dump_reader_if.master bus
);

`ifdef REG_DUMP_INDEX_EN
    localparam int unsigned BCNT_W = 3;
    localparam int unsigned BYTES_PER_REG = 5;
`else
    localparam int unsigned BCNT_W = 2;
    localparam int unsigned BYTES_PER_REG = 4;
`endif

    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_REG - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_REGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [31:0]       shift_q, shift_d;

    logic              out_valid;
    logic [7:0]        out_byte;
    logic              busy;
    logic              done;
    logic              accept;

    // State and datapath registers; reset clears the dump immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
        end
    end

    // Next-state and stream outputs; idx_q doubles as the registered debug address.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        out_valid = 1'b0;
        out_byte  = '0;
        busy      = (state_q != IDLE);
        done      = 1'b0;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end

            FETCH: begin
                shift_d = bus.dbg_data;
                bcnt_d  = '0;
                state_d = SEND;
            end

            SEND: begin
                out_valid = 1'b1;
                accept    = bus.out_ready;
`ifdef REG_DUMP_INDEX_EN
                // Byte 0 is the index; the data word only shifts on bytes 1..4.
                if (bcnt_q == '0) begin
                    out_byte = {3'b000, 5'(idx_q)};
                end else begin
                    out_byte = shift_q[31:24];
                    if (accept) begin
                        shift_d = shift_q << 8;
                    end
                end
`else
                out_byte = shift_q[31:24];
                if (accept) begin
                    shift_d = shift_q << 8;
                end
`endif
                if (accept) begin
                    if (bcnt_q == LAST_BYTE) begin
                        bcnt_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + ADDR_W'(1);
                            state_d = FETCH;
                        end
                    end else begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                    end
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.dbg_addr  = idx_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_byte;
    assign bus.busy      = busy;
    assign bus.done      = done;

endmodule
